// File: rtl/ahb_led_ctrl.sv
// ahb_led_ctrl: AHB-Lite slave driving led_out from a static pattern gated by a prescaled blink timer
// Ports: clk; reset (async, active-low); AHB-Lite slave HSEL/HADDR/HTRANS/HWRITE/HWDATA/HREADY in,
//        HRDATA/HREADYOUT/HRESP out; led_out registered LED drive.
// Map: 0x0 DATA, 0x4 BLINK, 0x8 PRESCALE, 0xC STATUS {cnt, 15'b0, phase} (read-only).
module ahb_led_ctrl #(
  parameter int LED_W = 8,
  parameter logic [15:0] PRESC_RST = 16'd49,
  parameter logic [7:0] LED_RST = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [LED_W-1:0] led_out
);
  localparam logic [31:0] LED_RST_X = 32'(LED_RST);
  localparam logic [LED_W-1:0] LED_INIT = LED_RST_X[LED_W-1:0];
  logic [1:0] addr_q;
  logic write_q, valid_q, phase_q;
  logic [LED_W-1:0] data_q, blink_q;
  logic [15:0] presc_q, cnt_q;
  logic wr, unused_ok;
  assign HREADYOUT = 1'b1;
  assign HRESP = 1'b0;
  assign wr = valid_q & write_q & HREADY;
  assign unused_ok = &{1'b0, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr_q <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (HREADY) begin
      addr_q <= HADDR[3:2];
      write_q <= HWRITE;
      valid_q <= HSEL & HTRANS[1];
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      data_q <= LED_INIT;
      blink_q <= '0;
      presc_q <= PRESC_RST;
    end else if (wr) begin
      if (addr_q == 2'd0) data_q <= HWDATA[LED_W-1:0];
      if (addr_q == 2'd1) blink_q <= HWDATA[LED_W-1:0];
      if (addr_q == 2'd2) presc_q <= HWDATA[15:0];
    end
  // a PRESCALE write restarts the blink cycle, taking priority over a wrap
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      phase_q <= 1'b0;
    end else if (wr && addr_q == 2'd2) begin
      cnt_q <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == presc_q) begin
      cnt_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) led_out <= LED_INIT;
    else led_out <= data_q & ~(blink_q & {LED_W{phase_q}});
  always_comb begin
    HRDATA = '0;
    if (valid_q && !write_q)
      HRDATA = addr_q == 2'd0 ? 32'(data_q) :
               addr_q == 2'd1 ? 32'(blink_q) :
               addr_q == 2'd2 ? {16'b0, presc_q} : {cnt_q, 15'b0, phase_q};
  end
endmodule
